// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetcher with a 2-entry output FIFO.
module instruction_fetch #(
    parameter int WORDSIZE    = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORDSIZE-1:0]    pc_addr,
    input  logic                   pc_valid,
    output logic                   pc_ready,
    input  logic                   flush,
    output logic                   mem_req,
    output logic [WORDSIZE-1:0]    mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [WORDSIZE-1:0]    instr_addr,
    output logic                   instr_fault
);
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
    state_t state, state_next;
    logic [WORDSIZE-1:0]    addr_q [2];
    logic [INSTR_WIDTH-1:0] data_q [2];
    logic                   fault_q [2];
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             count;
    logic                   accept, aligned, push, pop;
    logic [WORDSIZE-1:0]    push_addr;
    logic [INSTR_WIDTH-1:0] push_data;
    logic                   push_fault;

    assign pc_ready    = state == IDLE && count < 2'd2 && !flush && !rst;
    assign accept      = pc_valid && pc_ready;
    assign aligned     = pc_addr[1:0] == 2'b00;
    // A request is outstanding exactly while the FSM is in WAIT or DROP
    assign mem_req     = state != IDLE;
    assign instr_valid = count != 2'd0;
    assign pop         = instr_valid && instr_ready;
    assign instr_data  = instr_valid ? data_q[rd_ptr] : '0;
    assign instr_addr  = instr_valid ? addr_q[rd_ptr] : '0;
    assign instr_fault = instr_valid && fault_q[rd_ptr];

    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_addr  = mem_addr;
        push_data  = mem_rdata;
        push_fault = 1'b0;
        case (state)
            IDLE: begin
                if (accept && aligned) begin
                    state_next = WAIT;
                end else if (accept) begin
                    push       = 1'b1;
                    push_addr  = pc_addr;
                    push_data  = '0;
                    push_fault = 1'b1;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_next = IDLE;
                    push       = !flush;
                end else if (flush) begin
                    state_next = DROP;
                end
            end
            DROP:    state_next = mem_ack ? IDLE : DROP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) state <= rst ? IDLE : state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
            count    <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            if (accept && aligned)
                mem_addr <= pc_addr;
            if (flush) begin
                count  <= '0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            addr_q[wr_ptr]  <= push_addr;
            data_q[wr_ptr]  <= push_data;
            fault_q[wr_ptr] <= push_fault;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus checked every cycle against a queue-based fetch model.
module tb_instruction_fetch;
    localparam int W = 64;
    localparam int I = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pc_addr = '0;
    logic         pc_valid = 1'b0;
    logic         pc_ready;
    logic         flush = 1'b0;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic         mem_ack = 1'b0;
    logic [I-1:0] mem_rdata = '0;
    logic         instr_valid;
    logic         instr_ready = 1'b0;
    logic [I-1:0] instr_data;
    logic [W-1:0] instr_addr;
    logic         instr_fault;

    instruction_fetch #(.WORDSIZE(W), .INSTR_WIDTH(I)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_addr(instr_addr), .instr_fault(instr_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [I-1:0] d;
        logic         f;
    } entry_t;

    entry_t       q[$];
    bit           m_out = 1'b0;
    bit           m_disc = 1'b0;
    logic [W-1:0] m_addr = '0;
    bit           run = 1'b0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, act, exp);
        end
    endtask

    // Model: one outstanding fetch, possibly marked for discard, plus an in-order queue of results
    always @(posedge clk) begin
        bit rdy;
        rdy = !m_out && q.size() < 2 && !flush && !rst;
        if (rst) begin
            q.delete();
            m_out = 1'b0;
            m_disc = 1'b0;
            m_addr = '0;
        end else if (flush) begin
            q.delete();
            if (m_out && mem_ack) begin
                m_out = 1'b0;
                m_disc = 1'b0;
            end else if (m_out) begin
                m_disc = 1'b1;
            end
        end else begin
            if (q.size() > 0 && instr_ready)
                void'(q.pop_front());
            if (m_out && mem_ack) begin
                if (!m_disc)
                    q.push_back('{m_addr, mem_rdata, 1'b0});
                m_out = 1'b0;
                m_disc = 1'b0;
            end
            if (pc_valid && rdy) begin
                if (pc_addr[1:0] == 2'b00) begin
                    m_out = 1'b1;
                    m_addr = pc_addr;
                end else begin
                    q.push_back('{pc_addr, '0, 1'b1});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("pc_ready", pc_ready, !m_out && q.size() < 2 && !flush && !rst);
            chk("mem_req", mem_req, m_out);
            chk("mem_addr", mem_addr, m_addr);
            chk("instr_valid", instr_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("instr_data", instr_data, q[0].d);
                chk("instr_addr", instr_addr, q[0].a);
                chk("instr_fault", instr_fault, q[0].f);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [W-1:0] a, input logic [I-1:0] d);
        pc_addr = a;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        step();
        mem_rdata = d;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
    endtask

    initial begin
        step();
        run = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("lit_rst_req", mem_req, 0);
        chk("lit_rst_addr", mem_addr, 0);
        chk("lit_rst_valid", instr_valid, 0);
        chk("lit_rst_data", instr_data, 0);

        // Basic fetch
        pc_addr = 64'h20;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        @(negedge clk);
        chk("lit_basic_req", mem_req, 1);
        chk("lit_basic_addr", mem_addr, 64'h20);
        step();
        step();
        mem_rdata = 32'h00500093;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("lit_basic_valid", instr_valid, 1);
        chk("lit_basic_data", instr_data, 32'h00500093);
        chk("lit_basic_iaddr", instr_addr, 64'h20);
        chk("lit_basic_fault", instr_fault, 0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;

        // Backpressure
        fetch(64'h00, 32'h11111111);
        fetch(64'h20, 32'h22222222);
        @(negedge clk);
        chk("lit_bp_ready", pc_ready, 0);
        pc_addr = 64'h40;
        pc_valid = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("lit_bp_noreq", mem_req, 0);
        pc_valid = 1'b0;
        chk("lit_bp_head0", instr_addr, 64'h00);
        instr_ready = 1'b1;
        step();
        @(negedge clk);
        chk("lit_bp_head1", instr_addr, 64'h20);
        chk("lit_bp_data1", instr_data, 32'h22222222);
        step();
        @(negedge clk);
        chk("lit_bp_empty", instr_valid, 0);
        instr_ready = 1'b0;

        // Misaligned
        pc_addr = 64'h22;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        @(negedge clk);
        chk("lit_mis_req", mem_req, 0);
        chk("lit_mis_valid", instr_valid, 1);
        chk("lit_mis_fault", instr_fault, 1);
        chk("lit_mis_addr", instr_addr, 64'h22);
        chk("lit_mis_data", instr_data, 0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;

        // Flush in flight
        pc_addr = 64'h40;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        mem_rdata = 32'hdeadbeef;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("lit_fl_valid", instr_valid, 0);
        chk("lit_fl_ready", pc_ready, 1);

        // Flush coincident with ack, one entry buffered
        fetch(64'h60, 32'h33333333);
        pc_addr = 64'h80;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        step();
        flush = 1'b1;
        mem_rdata = 32'h44444444;
        mem_ack = 1'b1;
        step();
        flush = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("lit_fa_valid", instr_valid, 0);
        chk("lit_fa_req", mem_req, 0);

        // Misaligned burst with alternating ready: push and pop together
        for (int i = 0; i < 8; i++) begin
            pc_addr = 64'h200 + 64'(i * 4) + 64'h1;
            pc_valid = 1'b1;
            instr_ready = (i % 2) == 1;
            step();
        end
        pc_valid = 1'b0;
        instr_ready = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Reset mid-fetch
        pc_addr = 64'h100;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("lit_rw_req", mem_req, 0);
        chk("lit_rw_addr", mem_addr, 0);
        chk("lit_rw_valid", instr_valid, 0);
        mem_rdata = 32'h55555555;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("lit_rw_late", instr_valid, 0);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter WORDSIZE, default 64, SHALL set the width of all address ports.
REQ-002 Parameter INSTR_WIDTH, default 32, SHALL set the width of fetched instruction words.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled on posedge clk.
REQ-005 pc_addr  input  WORDSIZE  SHALL carry the fetch address from the program counter.
REQ-006 pc_valid  input  1  SHALL indicate that pc_addr is valid.
REQ-007 pc_ready  output  1  SHALL indicate that pc_addr is accepted this cycle.
REQ-008 flush  input  1  SHALL discard all buffered and in-flight fetches (redirect).
REQ-009 mem_req  output  1  SHALL request an instruction-memory read.
REQ-010 mem_addr  output  WORDSIZE  SHALL carry the read address.
REQ-011 mem_ack  input  1  SHALL indicate that mem_rdata is valid and the request is complete.
REQ-012 mem_rdata  input  INSTR_WIDTH  SHALL carry the instruction word returned by memory.
REQ-013 instr_valid  output  1  SHALL indicate that the FIFO head entry is presented to decode.
REQ-014 instr_ready  input  1  SHALL indicate that decode consumes the head entry.
REQ-015 instr_data / instr_addr / instr_fault  output  INSTR_WIDTH / WORDSIZE / 1  SHALL carry the head entry's instruction, fetch address and misalignment flag.

Function
REQ-016 FSM states SHALL be IDLE, WAIT and DROP; the output buffer SHALL be a 2-entry FIFO of {addr, data, fault}, with count ranging 0..2.
REQ-017 pc_ready SHALL be combinational: state==IDLE && count<2 && !flush && !rst.
REQ-018 Accept (pc_valid && pc_ready) with pc_addr[1:0]==0: latch mem_addr=pc_addr, set mem_req=1 next cycle, go to WAIT.
REQ-019 Accept with pc_addr[1:0]!=0: issue no memory request, push {pc_addr, 0, fault=1} at the next edge, remain in IDLE.
REQ-020 In WAIT, mem_req and mem_addr SHALL hold stable until the cycle mem_ack is high.
REQ-021 In WAIT, on mem_ack without flush: push {mem_addr, mem_rdata, 0}, deassert mem_req next cycle, go to IDLE. instr_valid for that entry SHALL rise 1 cycle after mem_ack.
REQ-022 mem_ack SHALL be ignored in IDLE.
REQ-023 In WAIT, flush without mem_ack: go to DROP; mem_req SHALL stay high until ack.
REQ-024 In DROP, on mem_ack: discard mem_rdata, deassert mem_req, go to IDLE. flush in DROP SHALL have no further effect.
REQ-025 In WAIT, flush coincident with mem_ack: discard the data, go to IDLE.
REQ-026 flush SHALL set count to 0 and clear instr_valid at the next edge; any push or pop in the same cycle SHALL be cancelled.
REQ-027 instr_valid SHALL equal (count!=0); a pop occurs on instr_valid && instr_ready.
REQ-028 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-029 The FIFO SHALL never overflow, because acceptance requires count<2 and at most one fetch is outstanding.
REQ-030 Head outputs SHALL stay stable while instr_valid && !instr_ready.
REQ-031 Read and write pointers SHALL wrap modulo 2.

Reset
REQ-032 While rst is high, the block SHALL go to IDLE with count=0 and pointers=0, and the following SHALL all be 0 at the next edge: mem_req, mem_addr, instr_valid, instr_data, instr_addr, instr_fault.
REQ-033 rst during WAIT SHALL abandon the request; a mem_ack arriving after reset is released SHALL be ignored.
REQ-034 rst SHALL take priority over flush and over all handshakes.

Verification
REQ-035 Basic fetch: pc_addr=0x20, pc_valid=1; mem_ack=1 with rdata=0x00500093 two cycles after mem_req -> mem_addr=0x20; instr_valid one cycle after ack with instr_data=0x00500093, instr_addr=0x20, instr_fault=0.
REQ-036 Backpressure: instr_ready=0 and three fetches at 0x00, 0x20, 0x40 -> two entries buffered, pc_ready=0 at count=2, no third mem_req; set instr_ready=1 -> outputs 0x00 then 0x20, in order.
REQ-037 Misaligned: pc_addr=0x22 -> mem_req stays 0; next cycle instr_valid=1, instr_fault=1, instr_addr=0x22, instr_data=0.
REQ-038 Flush in flight: flush one cycle after mem_req, mem_ack three cycles later -> FSM passes through DROP, nothing is pushed, instr_valid=0, pc_ready=1 after the ack.
REQ-039 Flush with ack: flush and mem_ack in the same cycle with one entry buffered -> count=0, instr_valid=0 next cycle, data discarded.
REQ-040 Reset mid-fetch: rst pulsed during WAIT -> mem_req=0 next cycle, all outputs 0, a late mem_ack produces no entry.
